// File: rtl/car_position_if.sv
// Frame-rate command/status bundle between the car movement FSM, the position
// controller and its consumers (sprite renderer, score/HUD).
interface car_position_if;
    logic       frame_tick;   // one-cycle pulse per video frame
    logic [1:0] car_move;     // 00 idle, 01 left, 10 right, 11 collide
    logic [9:0] car_x;        // car left-edge x position
    logic       car_visible;  // sprite enable, blinks while crashed
    logic       crashed;      // high from crash entry until recentred
    logic [7:0] crash_count;  // crashes since reset, saturating

    modport master (
        output frame_tick, car_move,
        input  car_x, car_visible, crashed, crash_count
    );

    modport slave (
        input  frame_tick, car_move,
        output car_x, car_visible, crashed, crash_count
    );
endinterface

// File: rtl/car_position_ctrl.sv
// Player car horizontal position controller. Once per video frame it turns the
// 2-bit move command into a clamped x position with lateral acceleration, and
// runs the crash sequence: freeze and blink, then glide back to X_START.
module car_position_ctrl #(
    parameter int X_MIN         = 240,
    parameter int X_MAX         = 400,
    parameter int X_START       = 320,
    parameter int MAX_STEP      = 4,
    parameter int CRASH_FRAMES  = 120,
    parameter int BLINK_FRAMES  = 8,
    parameter int RECENTER_STEP = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    car_position_if.slave bus
);

    localparam int VW = ($clog2(MAX_STEP + 1) < 3) ? 3 : $clog2(MAX_STEP + 1);
    localparam int CW = $clog2(CRASH_FRAMES + 1);

    localparam logic signed [10:0] X_MIN_S   = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
    localparam logic        [9:0]  X_START_U = 10'(X_START);
    localparam logic        [9:0]  RSTEP_U   = 10'(RECENTER_STEP);

    typedef enum logic [1:0] {RUN, CRASH, RECENTER} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t          state_q, state_n;
    dir_t            dir_q, dir_n;
    logic [9:0]      car_x_q, car_x_n;
    logic [VW-1:0]   vel_q, vel_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            vis_q, vis_n;
    logic            crashed_q, crashed_n;
    logic [7:0]      count_q, count_n;

    logic signed [10:0] x_s;
    logic signed [10:0] sum_s;
    logic [VW-1:0]      vel_up;
    logic [9:0]         x_gap;
    logic [9:0]         gap_step;
    logic               blink_hit;

    // Position math is widened to 11-bit signed so x - vel cannot wrap below 0.
    assign x_s      = signed'(11'(car_x_q));
    assign vel_up   = (vel_q >= VW'(MAX_STEP)) ? VW'(MAX_STEP) : vel_q + VW'(1);
    assign x_gap    = (car_x_q < X_START_U) ? X_START_U - car_x_q : car_x_q - X_START_U;
    assign gap_step = (x_gap < RSTEP_U) ? x_gap : RSTEP_U;
    assign blink_hit = ((32'(cnt_q) + 32'd1) % BLINK_FRAMES) == 0;

    // State register: everything updates together, reset wins in every state.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            dir_q     <= DIR_NONE;
            car_x_q   <= X_START_U;
            vel_q     <= '0;
            cnt_q     <= '0;
            vis_q     <= 1'b1;
            crashed_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_n;
            dir_q     <= dir_n;
            car_x_q   <= car_x_n;
            vel_q     <= vel_n;
            cnt_q     <= cnt_n;
            vis_q     <= vis_n;
            crashed_q <= crashed_n;
            count_q   <= count_n;
        end
    end

    // Next-state and next-output logic; nothing moves without frame_tick.
    always_comb begin
        // NOTE: hold-value defaults first, so no path leaves a signal unassigned (no latches).
        state_n   = state_q;
        dir_n     = dir_q;
        car_x_n   = car_x_q;
        vel_n     = vel_q;
        cnt_n     = cnt_q;
        vis_n     = vis_q;
        crashed_n = crashed_q;
        count_n   = count_q;
        sum_s     = x_s;

        if (bus.frame_tick) begin
            case (state_q)
                RUN: begin
                    case (bus.car_move)
                        2'b01: begin
                            vel_n   = (dir_q == DIR_LEFT) ? vel_up : VW'(1);
                            sum_s   = x_s - signed'(11'(vel_n));
                            car_x_n = (sum_s < X_MIN_S) ? X_MIN_S[9:0] : sum_s[9:0];
                            dir_n   = DIR_LEFT;
                        end
                        2'b10: begin
                            vel_n   = (dir_q == DIR_RIGHT) ? vel_up : VW'(1);
                            sum_s   = x_s + signed'(11'(vel_n));
                            car_x_n = (sum_s > X_MAX_S) ? X_MAX_S[9:0] : sum_s[9:0];
                            dir_n   = DIR_RIGHT;
                        end
                        2'b00: begin
                            vel_n = '0;
                            dir_n = DIR_NONE;
                        end
                        default: begin
                            state_n   = CRASH;
                            vel_n     = '0;
                            dir_n     = DIR_NONE;
                            crashed_n = 1'b1;
                            count_n   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                            cnt_n     = '0;
                        end
                    endcase
                end
                CRASH: begin
                    cnt_n = cnt_q + CW'(1);
                    if (blink_hit) vis_n = ~vis_q;
                    if (cnt_q == CW'(CRASH_FRAMES - 1)) begin
                        state_n = RECENTER;
                        vis_n   = 1'b1;
                        cnt_n   = '0;
                    end
                end
                RECENTER: begin
                    if (car_x_q == X_START_U) begin
                        state_n   = RUN;
                        crashed_n = 1'b0;
                    end else if (car_x_q < X_START_U) begin
                        car_x_n = car_x_q + gap_step;
                    end else begin
                        car_x_n = car_x_q - gap_step;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign bus.car_x       = car_x_q;
    assign bus.car_visible = vis_q;
    assign bus.crashed     = crashed_q;
    assign bus.crash_count = count_q;

endmodule
